// File: rtl/ss_pkg.sv
// Shared constants for the seven-segment scan driver: hex glyphs in
// active-high g..a order, the all-off segment pattern and the DP bit position.
package ss_pkg;

    localparam logic [7:0] SEG_OFF = 8'hFF;
    localparam int         DP_BIT  = 7;

    localparam logic [6:0] GLYPH_0 = 7'h3F;
    localparam logic [6:0] GLYPH_1 = 7'h06;
    localparam logic [6:0] GLYPH_2 = 7'h5B;
    localparam logic [6:0] GLYPH_3 = 7'h4F;
    localparam logic [6:0] GLYPH_4 = 7'h66;
    localparam logic [6:0] GLYPH_5 = 7'h6D;
    localparam logic [6:0] GLYPH_6 = 7'h7D;
    localparam logic [6:0] GLYPH_7 = 7'h07;
    localparam logic [6:0] GLYPH_8 = 7'h7F;
    localparam logic [6:0] GLYPH_9 = 7'h6F;
    localparam logic [6:0] GLYPH_A = 7'h77;
    localparam logic [6:0] GLYPH_B = 7'h7C;
    localparam logic [6:0] GLYPH_C = 7'h39;
    localparam logic [6:0] GLYPH_D = 7'h5E;
    localparam logic [6:0] GLYPH_E = 7'h79;
    localparam logic [6:0] GLYPH_F = 7'h71;

    localparam logic [6:0] GLYPH_NONE = 7'h00;

endpackage

// File: rtl/ss_scan_driver_if.sv
// Load bus between the application datapath and the scan driver:
// value/decimal-point strobe in, uncommitted-load status back.
interface ss_scan_driver_if #(
    parameter int DIGITS = 4
) ();

    logic                  Load;
    logic [4*DIGITS-1:0]   Digits;
    logic [DIGITS-1:0]     DP;
    logic                  Pending;

    modport master (
        output Load,
        output Digits,
        output DP,
        input  Pending
    );

    modport slave (
        input  Load,
        input  Digits,
        input  DP,
        output Pending
    );

endinterface

// File: rtl/ss_glyph_decoder.sv
// Purely combinational hex-to-seven-segment decoder (active-high, bit0 = a).
module ss_glyph_decoder
    import ss_pkg::*;
(
    input  logic [3:0] value_i,
    output logic [6:0] seg_o
);

    // Hex glyph lookup
    always_comb begin
        seg_o = GLYPH_NONE;
        case (value_i)
            4'h0:    seg_o = GLYPH_0;
            4'h1:    seg_o = GLYPH_1;
            4'h2:    seg_o = GLYPH_2;
            4'h3:    seg_o = GLYPH_3;
            4'h4:    seg_o = GLYPH_4;
            4'h5:    seg_o = GLYPH_5;
            4'h6:    seg_o = GLYPH_6;
            4'h7:    seg_o = GLYPH_7;
            4'h8:    seg_o = GLYPH_8;
            4'h9:    seg_o = GLYPH_9;
            4'hA:    seg_o = GLYPH_A;
            4'hB:    seg_o = GLYPH_B;
            4'hC:    seg_o = GLYPH_C;
            4'hD:    seg_o = GLYPH_D;
            4'hE:    seg_o = GLYPH_E;
            4'hF:    seg_o = GLYPH_F;
            default: seg_o = GLYPH_NONE;
        endcase
    end

endmodule

// File: rtl/ss_scan_driver.sv
// N-digit multiplexed common-anode seven-segment driver with PWM brightness
// and frame-synchronous double buffering. Option: SS_LEADING_ZERO_BLANK_EN.
module ss_scan_driver
    import ss_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int DIV_BITS = 17,
    parameter int PWM_BITS = 4
) (
    input  logic                 Clk,
    input  logic                 Reset,
    ss_scan_driver_if.slave      load_if,
    input  logic [PWM_BITS-1:0]  Brightness,
    input  logic                 Blank,
    output logic [DIGITS-1:0]    SegmentDrivers,
    output logic [7:0]           SevenSegment,
    output logic                 FrameStart
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [IDX_W-1:0]    IDX_LAST  = IDX_W'(DIGITS - 1);
    localparam logic [IDX_W-1:0]    IDX_ONE   = IDX_W'(1);
    localparam logic [DIV_BITS-1:0] COUNT_ONE = DIV_BITS'(1);
    localparam logic [DIGITS-1:0]   DIG_ONE   = DIGITS'(1);

    logic [DIV_BITS-1:0]  count_q, count_d;
    logic [IDX_W-1:0]     idx_q, idx_d;
    logic [4*DIGITS-1:0]  shadow_digits_q, shadow_digits_d;
    logic [DIGITS-1:0]    shadow_dp_q, shadow_dp_d;
    logic [4*DIGITS-1:0]  active_digits_q, active_digits_d;
    logic [DIGITS-1:0]    active_dp_q, active_dp_d;
    logic                 pending_q, pending_d;
    logic [DIGITS-1:0]    seg_drv_q, seg_drv_d;
    logic [7:0]           seven_seg_q, seven_seg_d;
    logic                 frame_start_q, frame_start_d;

    logic                 tick_s;
    logic                 frame_end_s;
    logic [3:0]           cur_nibble_s;
    logic                 cur_dp_s;
    logic [6:0]           glyph_s;
    logic [PWM_BITS-1:0]  phase_s;
    logic                 lit_s;
    logic [DIGITS-1:0]    lz_mask_s;

    // Refresh divider and scan index
    always_comb begin
        count_d     = count_q + COUNT_ONE;
        tick_s      = &count_q;
        frame_end_s = tick_s && (idx_q == IDX_LAST);
        if (frame_end_s) begin
            idx_d = '0;
        end else if (tick_s) begin
            idx_d = idx_q + IDX_ONE;
        end else begin
            idx_d = idx_q;
        end
    end

    // Shadow/active buffers: a Load on the boundary cycle bypasses the shadow stage
    always_comb begin
        shadow_digits_d = shadow_digits_q;
        shadow_dp_d     = shadow_dp_q;
        active_digits_d = active_digits_q;
        active_dp_d     = active_dp_q;
        pending_d       = pending_q;
        if (frame_end_s) begin
            if (load_if.Load) begin
                shadow_digits_d = load_if.Digits;
                shadow_dp_d     = load_if.DP;
                active_digits_d = load_if.Digits;
                active_dp_d     = load_if.DP;
                pending_d       = 1'b0;
            end else if (pending_q) begin
                active_digits_d = shadow_digits_q;
                active_dp_d     = shadow_dp_q;
                pending_d       = 1'b0;
            end else begin
                pending_d       = 1'b0;
            end
        end else if (load_if.Load) begin
            shadow_digits_d = load_if.Digits;
            shadow_dp_d     = load_if.DP;
            pending_d       = 1'b1;
        end else begin
            pending_d       = pending_q;
        end
    end

    // Select the active nibble and DP of the digit currently being scanned
    always_comb begin
        cur_nibble_s = active_digits_q[{idx_q, 2'b00} +: 4];
        cur_dp_s     = active_dp_q[idx_q];
    end

    ss_glyph_decoder u_glyph (
        .value_i (cur_nibble_s),
        .seg_o   (glyph_s)
    );

`ifdef SS_LEADING_ZERO_BLANK_EN
    // Blank zero digits from the most significant end until a nonzero digit or a set DP
    always_comb begin : lz_blank
        logic run_v;
        lz_mask_s = '0;
        run_v     = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            if (run_v && (active_digits_q[4*k +: 4] == 4'h0) && !active_dp_q[k]) begin
                lz_mask_s[k] = 1'b1;
            end else begin
                run_v = 1'b0;
            end
        end
    end
`else
    assign lz_mask_s = '0;
`endif

    // Output-stage next values: digit enable, PWM-gated segments, frame marker
    always_comb begin
        phase_s       = count_q[DIV_BITS-1 -: PWM_BITS];
        lit_s         = (phase_s < Brightness);
        seg_drv_d     = ~(DIG_ONE << idx_q);
        frame_start_d = (idx_q == '0) && (count_q == '0);
        seven_seg_d   = SEG_OFF;
        if (Blank || !lit_s || lz_mask_s[idx_q]) begin
            seven_seg_d = SEG_OFF;
        end else begin
            seven_seg_d[DP_BIT] = ~cur_dp_s;
            seven_seg_d[6:0]    = ~glyph_s;
        end
    end

    // State and output registers; Reset discards any uncommitted shadow data
    always_ff @(posedge Clk) begin
        if (Reset) begin
            count_q         <= '0;
            idx_q           <= '0;
            shadow_digits_q <= '0;
            shadow_dp_q     <= '0;
            active_digits_q <= '0;
            active_dp_q     <= '0;
            pending_q       <= 1'b0;
            seg_drv_q       <= '1;
            seven_seg_q     <= SEG_OFF;
            frame_start_q   <= 1'b0;
        end else begin
            count_q         <= count_d;
            idx_q           <= idx_d;
            shadow_digits_q <= shadow_digits_d;
            shadow_dp_q     <= shadow_dp_d;
            active_digits_q <= active_digits_d;
            active_dp_q     <= active_dp_d;
            pending_q       <= pending_d;
            seg_drv_q       <= seg_drv_d;
            seven_seg_q     <= seven_seg_d;
            frame_start_q   <= frame_start_d;
        end
    end

    assign SegmentDrivers  = seg_drv_q;
    assign SevenSegment    = seven_seg_q;
    assign FrameStart      = frame_start_q;
    assign load_if.Pending = pending_q;

endmodule

// File: tb/tb_ss_scan_driver.sv
// Self-checking bench for ss_scan_driver with DIGITS=4, DIV_BITS=4, PWM_BITS=2.
module tb_ss_scan_driver;

    localparam int DIGITS   = 4;
    localparam int DIV_BITS = 4;
    localparam int PWM_BITS = 2;
    localparam int SLOT     = 16;
    localparam int FRAME    = 64;

`ifdef SS_LEADING_ZERO_BLANK_EN
    localparam logic [31:0] ZERO_FRAME = 32'hFFFFFFC0;
    localparam logic [31:0] LZ_FRAME   = 32'hFFFF92C0;
`else
    localparam logic [31:0] ZERO_FRAME = 32'hC0C0C0C0;
    localparam logic [31:0] LZ_FRAME   = 32'hC0C092C0;
`endif

    logic                Clk = 1'b0;
    logic                Reset;
    logic [PWM_BITS-1:0] Brightness;
    logic                Blank;
    logic [DIGITS-1:0]   SegmentDrivers;
    logic [7:0]          SevenSegment;
    logic                FrameStart;

    ss_scan_driver_if #(.DIGITS(DIGITS)) lif ();

    ss_scan_driver #(
        .DIGITS   (DIGITS),
        .DIV_BITS (DIV_BITS),
        .PWM_BITS (PWM_BITS)
    ) dut (
        .Clk            (Clk),
        .Reset          (Reset),
        .load_if        (lif),
        .Brightness     (Brightness),
        .Blank          (Blank),
        .SegmentDrivers (SegmentDrivers),
        .SevenSegment   (SevenSegment),
        .FrameStart     (FrameStart)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [3:0] drv;
        logic [7:0] seg;
        logic       fs;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   pos    = 0;   // rising edges since Reset was released

    task automatic step();
        @(posedge Clk);
        if (Reset) pos = 0;
        else       pos++;
        #1;
    endtask

    task automatic load(input logic [15:0] d, input logic [3:0] p);
        lif.Load   = 1'b1;
        lif.Digits = d;
        lif.DP     = p;
        step();
        lif.Load   = 1'b0;
    endtask

    task automatic goto_phase(input int ph);
        int n = 0;
        while ((pos % FRAME != ph) && (n < 2*FRAME)) begin
            step();
            n++;
        end
        checks++;
        if ((pos % FRAME) !== ph) begin
            errors++;
            $display("FAIL goto_phase: got frame position %0d, required %0d", pos % FRAME, ph);
        end
    endtask

    task automatic check_pending(input logic exp, input string name);
        checks++;
        if (lif.Pending !== exp) begin
            errors++;
            $display("FAIL %s pending: got %b, required %b", name, lif.Pending, exp);
        end
    endtask

    // One full frame: push expected outputs per edge, pop and compare after it
    task automatic check_frame(input logic [31:0] exp_seg, input int bright,
                               input bit blank, input string name);
        exp_t       e;
        logic [3:0] one_v;
        int         p, idx, ph;
        one_v = 4'b0001;
        goto_phase(0);
        for (int i = 0; i < FRAME; i++) begin
            p     = pos + 1;
            idx   = ((p - 1) / SLOT) % DIGITS;
            ph    = ((p - 1) % SLOT) / (SLOT / 4);
            e.drv = ~(one_v << idx);
            e.seg = (blank || ph >= bright) ? 8'hFF : exp_seg[idx*8 +: 8];
            e.fs  = (((p - 1) % FRAME) == 0);
            sb_q.push_back(e);
            step();
            e = sb_q.pop_front();
            checks++;
            if (SegmentDrivers !== e.drv) begin
                errors++;
                $display("FAIL %s drivers at edge %0d: got %h, required %h", name, pos, SegmentDrivers, e.drv);
            end
            checks++;
            if (SevenSegment !== e.seg) begin
                errors++;
                $display("FAIL %s segments at edge %0d: got %h, required %h", name, pos, SevenSegment, e.seg);
            end
            checks++;
            if (FrameStart !== e.fs) begin
                errors++;
                $display("FAIL %s framestart at edge %0d: got %b, required %b", name, pos, FrameStart, e.fs);
            end
        end
    endtask

    task automatic check_reset_outputs(input string name);
        checks++;
        if (SegmentDrivers !== 4'hF || SevenSegment !== 8'hFF || FrameStart !== 1'b0) begin
            errors++;
            $display("FAIL %s outputs: got drv=%h seg=%h fs=%b, required drv=f seg=ff fs=0",
                     name, SegmentDrivers, SevenSegment, FrameStart);
        end
        check_pending(1'b0, name);
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        step();
        step();
        check_reset_outputs("reset");
        Reset = 1'b0;
        check_frame(ZERO_FRAME, 3, 1'b0, "scan_frame1");
        check_frame(ZERO_FRAME, 3, 1'b0, "scan_frame2");
    endtask

    task automatic test_double_buffer();
        logic [31:0] zf;
        logic [7:0]  old_d3;
        zf     = ZERO_FRAME;
        old_d3 = zf[31:24];
        goto_phase(20);
        load(16'h12AF, 4'b0100);
        check_pending(1'b1, "dbuf_after_load");
        goto_phase(49);
        checks++;
        if (SevenSegment !== old_d3) begin
            errors++;
            $display("FAIL dbuf_old_value: got %h, required %h", SevenSegment, old_d3);
        end
        goto_phase(63);
        check_pending(1'b1, "dbuf_before_boundary");
        step();
        check_pending(1'b0, "dbuf_after_boundary");
        check_frame(32'hF924888E, 3, 1'b0, "dbuf_hex");
    endtask

    task automatic test_back_to_back();
        goto_phase(10);
        load(16'h1111, 4'b0000);
        goto_phase(30);
        load(16'h2222, 4'b0000);
        check_pending(1'b1, "b2b_pending");
        check_frame(32'hA4A4A4A4, 3, 1'b0, "b2b_last_wins");
        goto_phase(63);
        load(16'h3333, 4'b0000);
        check_pending(1'b0, "boundary_load_pending");
        check_frame(32'hB0B0B0B0, 3, 1'b0, "boundary_load");
    endtask

    task automatic test_brightness();
        Brightness = 2'd1;
        check_frame(32'hB0B0B0B0, 1, 1'b0, "bright1");
        Brightness = 2'd0;
        check_frame(32'hB0B0B0B0, 0, 1'b0, "bright0");
        Brightness = 2'd3;
        Blank      = 1'b1;
        check_frame(32'hB0B0B0B0, 3, 1'b1, "blank");
        Blank      = 1'b0;
    endtask

    task automatic test_reset_pending();
        goto_phase(5);
        load(16'h4567, 4'b1111);
        check_pending(1'b1, "rstpend_loaded");
        Reset = 1'b1;
        step();
        step();
        check_reset_outputs("rstpend_in_reset");
        Reset = 1'b0;
        check_frame(ZERO_FRAME, 3, 1'b0, "rstpend_zero");
        check_pending(1'b0, "rstpend_after");
    endtask

    task automatic test_leading_zero();
        load(16'h0050, 4'b0000);
        check_frame(LZ_FRAME, 3, 1'b0, "lz_0050");
        load(16'h0050, 4'b1000);
        check_frame(32'h40C092C0, 3, 1'b0, "lz_0050_dp3");
    endtask

    initial begin
        Reset      = 1'b1;
        Brightness = 2'd3;
        Blank      = 1'b0;
        lif.Load   = 1'b0;
        lif.Digits = 16'h0000;
        lif.DP     = 4'b0000;
        test_reset();
        test_double_buffer();
        test_back_to_back();
        test_brightness();
        test_reset_pending();
        test_leading_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/ss_scan_driver.md
# ss_scan_driver

Parametrised, time-multiplexed seven-segment display driver for an N-digit common-anode display. It is the successor to the fixed 4-digit BCD driver.
- Generalised: digit count, refresh rate and brightness resolution are parameters.
- Added behaviour: hexadecimal glyphs, per-digit decimal points, internal brightness PWM, and frame-synchronous double-buffered updates so a display never shows a torn value.
- Position: between the application datapath (which loads values) and the board's digit-enable and segment pins.

## Interface
- DIGITS, 4, number of multiplexed digits (2..8)
- DIV_BITS, 17, refresh divider width; one digit slot lasts 2^DIV_BITS Clk cycles
- PWM_BITS, 4, brightness resolution; DIV_BITS > PWM_BITS is required
- Clk  input  1  system clock
- Reset  input  1  synchronous, active-high
- Load  input  1  one-cycle strobe; captures Digits/DP into shadow registers
- Digits  input  4*DIGITS  nibble k (bits 4k+3:4k) is the value for digit k; digit 0 is rightmost
- DP  input  DIGITS  decimal point for digit k, active-high
- Brightness  input  PWM_BITS  duty level; 0 = dark
- Blank  input  1  forces all segments off while high; scanning continues
- SegmentDrivers  output  DIGITS  digit enables, active-low, one-hot
- SevenSegment  output  8  active-low; bit0 = a … bit6 = g, bit7 = DP
- FrameStart  output  1  one-cycle pulse when digit 0 becomes active
- Pending  output  1  high while the shadow registers hold an uncommitted Load

## Operation
- Divider: Count (DIV_BITS) increments every cycle and wraps. Tick = &Count.
- Scan index:
  - idx (0..DIGITS-1) advances on each Tick and wraps from DIGITS-1 to 0.
  - Frame boundary = Tick with idx == DIGITS-1.
- Double buffer:
  - Load writes shadow Digits/DP and sets Pending.
  - At a frame boundary with Pending=1: active <= shadow, Pending <= 0.
  - Load on the frame-boundary cycle: the incoming Load data is committed directly and Pending stays 0.
  - Load while Pending=1: overwrites the shadow. Last write wins.
- Glyph: the active nibble for digit idx is decoded as hex. 0–9 as standard; A, b, C, d, E, F.
- PWM:
  - phase = Count[DIV_BITS-1 -: PWM_BITS].
  - Segments and DP are lit only when phase < Brightness.
  - Brightness is sampled live with no buffering. Maximum duty is (2^PWM_BITS-1)/2^PWM_BITS.
- SevenSegment = 8'hFF when Reset, Blank, or the PWM-off phase applies. Otherwise it is the inverted glyph plus the inverted DP of digit idx.

## Timing
- Reset values: Count=0, idx=0, active and shadow=0, Pending=0, SegmentDrivers=all ones, SevenSegment=8'hFF, FrameStart=0.
- All outputs are registered, one cycle behind idx/Count.
- First cycle after Reset deasserts: SegmentDrivers = ~1 (digit 0).
- Reset mid-frame or with Pending=1: the state above is restored and the shadow contents are discarded.
- FrameStart pulses on the same cycle SegmentDrivers changes to digit 0. The period is DIGITS·2^DIV_BITS cycles.
- Display latency from Load: ≤ one frame plus 1 cycle.

## Configuration
- SS_LEADING_ZERO_BLANK_EN defined:
  - Scanning from digit DIGITS-1 downward, zero-valued digits are blanked (0x7F on segments, DP off) until the first nonzero digit or the first set DP bit.
  - Digit 0 is never blanked.
  - Blanking uses the active registers only.
- Macro undefined: every digit shows its glyph, including leading zeros.

## Structure
- Package ss_pkg:
  - Glyph constants for 0–F in active-high g..a order.
  - Constants SEG_OFF = 8'hFF and DP_BIT = 7.
- One sub-module, ss_glyph_decoder: 4-bit value in, 7-bit active-high segments out, purely combinational.
- Top level holds the divider, scan index, shadow/active registers, PWM compare and output registers.

## Test plan
All scenarios use DIGITS=4, DIV_BITS=4, PWM_BITS=2.
- Reset then release, Brightness=3: SegmentDrivers sequence E,D,B,7,E… with each step 16 cycles. FrameStart every 64 cycles.
- Load Digits=16'h12AF, DP=4'b0100 mid-frame: Pending=1 until the frame boundary, then the old value persists to frame end. Next frame: digit0=0x8E (F), digit1=0x88 (A), digit2=0x24 (2 with DP lit), digit3=0xF9 (1).
- Two Loads in one frame (16'h1111 then 16'h2222): only 2222 is displayed. Load exactly on the boundary Tick: committed immediately and Pending stays 0.
- Brightness=1: segments lit during phase 0 only, i.e. 4 of 16 cycles per slot. Brightness=0: SevenSegment constantly 8'hFF. Blank=1: 8'hFF while SegmentDrivers still rotate.
- Reset asserted with Pending=1: after release, all digits show 0 (0xC0) and Pending=0.
- With SS_LEADING_ZERO_BLANK_EN and Digits=16'h0050: digits 3 and 2 show 0xFF, digit1=0x92, digit0=0xC0. With DP=4'b1000: digit 3 shows 0x40.
